// File: rtl/seg7_scan_capture.sv
// Passive monitor for a multiplexed active-low 7-segment bus; rebuilds per-digit codes.
// Optional SEG7_SCAN_SYNC_EN adds a two-flop synchronizer ahead of the input register.
module seg7_scan_capture #(
  parameter int unsigned NUM_DIGITS    = 8,
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_DIGITS-1:0]     anode,
  input  logic [7:0]                cathode,
  input  logic                      err_clr,
  output logic [4*NUM_DIGITS-1:0]   digits,
  output logic [NUM_DIGITS-1:0]     dp,
  output logic [NUM_DIGITS-1:0]     seen,
  output logic                      frame_done,
  output logic                      err
);

  localparam int unsigned SW = NUM_DIGITS + 8;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_CAP = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic {ST_WAIT, ST_CAPTURED} state_e;

  state_e                    state_q, state_d;
  logic [SW-1:0]             bus_in;
  logic [SW-1:0]             samp_q;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0]   digits_q, digits_d;
  logic [NUM_DIGITS-1:0]     dp_q, dp_d;
  logic [NUM_DIGITS-1:0]     seen_q, seen_d;
  logic                      frame_done_q, frame_done_d;
  logic                      err_q, err_d;

  logic [NUM_DIGITS-1:0]     s_an;
  logic [7:0]                s_cat;
  logic [NUM_DIGITS-1:0]     an_low;
  logic                      chg;
  logic                      one_low;
  logic                      multi_low;
  logic                      dwell_done;
  logic [4:0]                dec;

`ifdef SEG7_SCAN_SYNC_EN
  logic [SW-1:0] sync1_q, sync2_q;

  // Two-flop synchronizer; idles at all-ones like the bus itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= {anode, cathode};
      sync2_q <= sync1_q;
    end
  end

  assign bus_in = sync2_q;
`else
  assign bus_in = {anode, cathode};
`endif

  // {valid, code}; valid=0 marks an unrecognised segment pattern.
  function automatic logic [4:0] decode(input logic [6:0] seg);
    logic [4:0] r;
    case (seg)
      7'b0000001: r = 5'h10;
      7'b1001111: r = 5'h11;
      7'b0010010: r = 5'h12;
      7'b0000110: r = 5'h13;
      7'b1001100: r = 5'h14;
      7'b0100100: r = 5'h15;
      7'b0100000: r = 5'h16;
      7'b0001111: r = 5'h17;
      7'b0000000: r = 5'h18;
      7'b0000100: r = 5'h19;
      7'b1111111: r = 5'h1A;
      default:    r = 5'h0F;
    endcase
    return r;
  endfunction

  assign s_an       = samp_q[SW-1:8];
  assign s_cat      = samp_q[7:0];
  assign an_low     = ~s_an;
  assign chg        = (bus_in != samp_q);
  assign one_low    = (an_low != '0) && ((an_low & (an_low - NUM_DIGITS'(1))) == '0);
  assign multi_low  = (an_low != '0) && !one_low;
  assign dwell_done = !chg && (cnt_q == CNT_CAP);
  assign dec        = decode(s_cat[7:1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_WAIT;
      samp_q       <= '1;
      cnt_q        <= '0;
      digits_q     <= '0;
      dp_q         <= '0;
      seen_q       <= '0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      samp_q       <= bus_in;
      cnt_q        <= cnt_d;
      digits_q     <= digits_d;
      dp_q         <= dp_d;
      seen_q       <= seen_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    logic cap;
    logic err_set;
    state_d      = state_q;
    cnt_d        = cnt_q;
    digits_d     = digits_q;
    dp_d         = dp_q;
    seen_d       = seen_q;
    frame_done_d = 1'b0;
    err_d        = err_q;
    cap          = 1'b0;
    err_set      = 1'b0;

    if (chg)                  cnt_d = '0;
    else if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);

    case (state_q)
      ST_WAIT: begin
        if (dwell_done && one_low) begin
          state_d = ST_CAPTURED;
          cap     = 1'b1;
        end
      end
      ST_CAPTURED: begin
        if (chg) state_d = ST_WAIT;
      end
      default: state_d = ST_WAIT;
    endcase

    // Counter saturation makes the multi-anode error fire once per dwell.
    if (dwell_done && multi_low) err_set = 1'b1;

    // A full seen vector pulses frame_done and clears; a same-edge capture survives.
    if (&seen_q) begin
      frame_done_d = 1'b1;
      seen_d       = '0;
    end

    if (cap) begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        if (an_low[i]) begin
          digits_d[4*i +: 4] = dec[3:0];
          dp_d[i]            = ~s_cat[0];
          seen_d[i]          = 1'b1;
        end
      end
      if (!dec[4]) err_set = 1'b1;
    end

    if (err_set)      err_d = 1'b1;
    else if (err_clr) err_d = 1'b0;
  end

  assign digits     = digits_q;
  assign dp         = dp_q;
  assign seen       = seen_q;
  assign frame_done = frame_done_q;
  assign err        = err_q;

endmodule

// File: doc/seg7_scan_capture.md
Name: seg7_scan_capture

Overview:
- Passive monitor that observes the multiplexed 7-segment display bus (active-low digit anodes and active-low cathodes) and reconstructs the value shown on each digit.
- Inverse of the BCD-to-7-segment decoder: maps cathode patterns back to 4-bit codes.
- Sits beside the display driver in the Game of Life top level, so on-board self-check logic and the testbench can read the displayed values without decoding pins.

Parameters:
- NUM_DIGITS, 8, number of multiplexed digits (anode width).
- STABLE_CYCLES, 4, consecutive identical samples required before capture (>=1).
- CNT_W, 8, width of the stability counter (2^CNT_W > STABLE_CYCLES).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- anode  in  NUM_DIGITS  digit enables, active-low, one-hot-low when driven.
- cathode  in  8  segments, active-low; [7:1]=a..g, [0]=dp.
- err_clr  in  1  synchronous clear of err.
- digits  out  4*NUM_DIGITS  decoded code per digit; digit i at [4i+3:4i].
- dp  out  NUM_DIGITS  decimal point lit, per digit.
- seen  out  NUM_DIGITS  digit captured since the last frame_done.
- frame_done  out  1  one-cycle pulse when every digit has been captured.
- err  out  1  sticky error flag.

Behaviour:
- Reset (async, rst_n=0): all outputs 0, sample registers all-ones (bus idle), counter 0, FSM in WAIT.
- Input register: anode and cathode are registered every clk into s_an and s_cat.
- Stability counter:
  - cleared to 0 when {s_an,s_cat} differs from its previous value.
  - otherwise increments, saturating at STABLE_CYCLES.
- FSM states: WAIT, CAPTURED.
  - WAIT -> CAPTURED when the counter equals STABLE_CYCLES-1, the value is unchanged, and s_an has exactly one bit low. The capture happens on that edge.
  - CAPTURED -> WAIT on any change of {s_an,s_cat}.
  - Only one capture per dwell.
- Latency: inputs applied before edge k and held constant update digits at edge k+STABLE_CYCLES.
- Anode all-high (blanking gap): never captured, no error.
- Two or more anode bits low and stable for STABLE_CYCLES: no capture, set err.
- Decode on s_cat[7:1]. Pattern -> code:
  - 0000001 -> 0
  - 1001111 -> 1
  - 0010010 -> 2
  - 0000110 -> 3
  - 1001100 -> 4
  - 0100100 -> 5
  - 0100000 -> 6
  - 0001111 -> 7
  - 0000000 -> 8
  - 0000100 -> 9
  - 1111111 -> 4'hA (blank)
  - any other pattern -> 4'hF and set err.
- dp[i] = ~s_cat[0] at capture.
- Capture of digit i writes digits[i], dp[i] and sets seen[i].
- frame_done:
  - when the set in progress makes seen all-ones, frame_done=1 for exactly one cycle on the next edge, and seen clears to 0 on that same edge.
  - a capture on the same edge as the clear leaves seen = only that digit's bit.
- err: set by the conditions above. err_clr clears it. Simultaneous set and clear -> set wins.
- Reset mid-dwell: everything returns to reset values immediately. A pattern still present after reset needs a full STABLE_CYCLES dwell before capture.
- Re-capturing a digit that is already seen overwrites its value and leaves seen unchanged.

Optional Feature:
- Macro SEG7_SCAN_SYNC_EN.
- Defined: anode and cathode pass through a two-flop synchronizer (reset to all-ones) before the input register, for asynchronous pins or a foreign clock. Capture latency becomes STABLE_CYCLES+2.
- Undefined: single input register only; latency STABLE_CYCLES. Inputs must be synchronous to clk.

Test Plan:
- Reset then idle bus (anode=8'hFF): digits=0, seen=0, err=0, frame_done never pulses.
- anode=8'hFE, cathode=8'h25 held 4 cycles: digits[3:0]=4'h2, dp[0]=0, seen=8'h01 at edge k+4. Held only 3 cycles then changed: no capture.
- Scan digits 0..7 showing 0..7, each held 6 cycles (cathode 03,9F,25,0D,99,49,41,1F): digits=32'h76543210, a single frame_done pulse, seen=0 afterward.
- anode=8'hFB, cathode=8'hFE: digits[11:8]=4'hA, dp[2]=1. Then cathode=8'hFF: dp[2]=0, code still 4'hA, err stays 0.
- anode=8'hFE, cathode=8'h55 held: digits[3:0]=4'hF and err=1. err_clr pulse clears err. err_clr asserted together with a new error leaves err=1.
- anode=8'hFC held (two low): no capture, err=1. rst_n pulsed mid-dwell of a valid digit: outputs 0, and capture needs a fresh 4-cycle dwell.
